// File: rtl/div_pkg.sv
// Shared definitions for the signed sequential divider.
//   DEF_WIDTH    default operand width (dividend is twice this)
//   DEF_CNT_W    iteration counter width for the default width
//   div_state_e  controller state encoding
package div_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ITER    = 2'd1,
      CORRECT = 2'd2,
      DONE    = 2'd3
   } div_state_e;

endpackage

// File: rtl/booth_companion_divider_if.sv
// Operand/result bundle of the divider.
//   start, dividend_in, divisor_in     : requester -> divider
//   busy, done, quotient_out,
//   remainder_out, div_by_zero,
//   overflow                           : divider -> requester
// Handshake: start is sampled on a rising edge only while busy=0; that
// edge captures the operands. busy stays high from the next cycle up to
// and including the single done cycle; start seen while busy=1 is
// dropped. Results and flags are valid while done=1 and hold afterwards.
interface booth_companion_divider_if #(
   parameter int WIDTH = 8
);

   logic                   start;
   logic [2*WIDTH-1:0]     dividend_in;
   logic [WIDTH-1:0]       divisor_in;
   logic                   busy;
   logic                   done;
   logic [WIDTH-1:0]       quotient_out;
   logic [WIDTH-1:0]       remainder_out;
   logic                   div_by_zero;
   logic                   overflow;

   modport master (
      output start, dividend_in, divisor_in,
      input  busy, done, quotient_out, remainder_out, div_by_zero, overflow
   );

   modport slave (
      input  start, dividend_in, divisor_in,
      output busy, done, quotient_out, remainder_out, div_by_zero, overflow
   );

endinterface

// File: rtl/nrd_step.sv
// One radix-2 non-restoring division iteration on magnitudes.
//   r_in  : partial remainder, WIDTH+1 bits, two's complement
//   q_in  : dividend low bits / developing quotient
//   d_in  : divisor magnitude
//   r_out : partial remainder after shift and add/subtract
//   q_out : quotient register shifted with the new quotient bit
module nrd_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   r_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH:0]   r_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH:0] r_shift;
   logic [WIDTH:0] d_ext;
   logic [WIDTH:0] r_new;

   always_comb begin
      // |R| never exceeds the divisor, so dropping R's top bit while
      // shifting keeps 2R+bit exact in WIDTH+1 bits.
      r_shift = {r_in[WIDTH-1:0], q_in[WIDTH-1]};
      d_ext   = {1'b0, d_in};
      if (r_in[WIDTH] == 1'b0) begin
         r_new = r_shift - d_ext;
      end else begin
         r_new = r_shift + d_ext;
      end
      r_out = r_new;
      q_out = {q_in[WIDTH-2:0], ~r_new[WIDTH]};
   end

endmodule

// File: rtl/booth_companion_divider.sv
// Signed 2W/W sequential divider, one quotient bit per clock.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : start/busy/done operand and result bundle (slave side)
//   state_dbg  : current controller state
// Quotient truncates toward zero; remainder takes the dividend's sign.
// Divide-by-zero and unrepresentable quotients finish with zeroed results
// and the matching flag set.
module booth_companion_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   booth_companion_divider_if.slave bus,
   output div_state_e               state_dbg
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_e         state_q, state_d;
   logic [WIDTH:0]     r_q, r_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic               q_sign_q, q_sign_d;
   logic               r_sign_q, r_sign_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               dbz_q, dbz_d;
   logic               ovf_q, ovf_d;

   logic [2*WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0]   dvs_mag;
   logic [WIDTH:0]     step_r;
   logic [WIDTH-1:0]   step_q;
   logic [WIDTH-1:0]   rem_mag;
   logic               q_range_err;

   nrd_step #(.WIDTH(WIDTH)) u_step (
      .r_in  (r_q),
      .q_in  (q_q),
      .d_in  (d_q),
      .r_out (step_r),
      .q_out (step_q)
   );

   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      q_d      = q_q;
      d_d      = d_q;
      q_sign_d = q_sign_q;
      r_sign_d = r_sign_q;
      count_d  = count_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      dbz_d    = dbz_q;
      ovf_d    = ovf_q;

      // Negation taken as unsigned 0-x: the most negative value maps to
      // its exact magnitude (e.g. 0x8000 -> 32768).
      dvd_mag = bus.dividend_in[2*WIDTH-1] ? ({(2*WIDTH){1'b0}} - bus.dividend_in)
                                           : bus.dividend_in;
      dvs_mag = bus.divisor_in[WIDTH-1] ? ({WIDTH{1'b0}} - bus.divisor_in)
                                        : bus.divisor_in;

      // Final restore step folded into WIDTH bits; the true remainder
      // lies in [0, |divisor|) so the carry out is irrelevant.
      rem_mag = r_q[WIDTH] ? (r_q[WIDTH-1:0] + d_q) : r_q[WIDTH-1:0];
      q_range_err = q_sign_q ? (q_q > NEG_MAX) : (q_q > POS_MAX);

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               q_sign_d = bus.dividend_in[2*WIDTH-1] ^ bus.divisor_in[WIDTH-1];
               r_sign_d = bus.dividend_in[2*WIDTH-1];
               d_d      = dvs_mag;
               r_d      = {1'b0, dvd_mag[2*WIDTH-1:WIDTH]};
               q_d      = dvd_mag[WIDTH-1:0];
               count_d  = '0;
               dbz_d    = 1'b0;
               ovf_d    = 1'b0;
               if (bus.divisor_in == '0) begin
                  dbz_d   = 1'b1;
                  quot_d  = '0;
                  rem_d   = '0;
                  state_d = DONE;
               end else if (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag) begin
                  // Quotient magnitude would need more than WIDTH bits.
                  ovf_d   = 1'b1;
                  quot_d  = '0;
                  rem_d   = '0;
                  state_d = DONE;
               end else begin
                  state_d = ITER;
               end
            end
         end
         ITER: begin
            r_d     = step_r;
            q_d     = step_q;
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(WIDTH-1)) begin
               state_d = CORRECT;
            end
         end
         CORRECT: begin
            r_d = {1'b0, rem_mag};
            if (q_range_err) begin
               ovf_d  = 1'b1;
               quot_d = '0;
               rem_d  = '0;
            end else begin
               quot_d = q_sign_q ? ({WIDTH{1'b0}} - q_q) : q_q;
               rem_d  = r_sign_q ? ({WIDTH{1'b0}} - rem_mag) : rem_mag;
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         r_q      <= '0;
         q_q      <= '0;
         d_q      <= '0;
         q_sign_q <= 1'b0;
         r_sign_q <= 1'b0;
         count_q  <= '0;
         quot_q   <= '0;
         rem_q    <= '0;
         dbz_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         q_q      <= q_d;
         d_q      <= d_d;
         q_sign_q <= q_sign_d;
         r_sign_q <= r_sign_d;
         count_q  <= count_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
         dbz_q    <= dbz_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.busy          = (state_q != IDLE);
   assign bus.done          = (state_q == DONE);
   assign bus.quotient_out  = quot_q;
   assign bus.remainder_out = rem_q;
   assign bus.div_by_zero   = dbz_q;
   assign bus.overflow      = ovf_q;
   assign state_dbg         = state_q;

endmodule
